// File: rtl/pipe_dmem_pkg.sv
// pipe_dmem_pkg: shared size encodings, FSM states and lane helpers for the MEM-stage data RAM
package pipe_dmem_pkg;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;
  typedef enum logic {CLEAR, RUN} state_t;
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lane);
    return size == SZ_BYTE ? 4'b0001 << lane :
           size == SZ_HALF ? (lane[1] ? 4'b1100 : 4'b0011) :
           size == SZ_WORD ? 4'b1111 : 4'b0000;
  endfunction
  function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] lane);
    return size == SZ_BYTE || (size == SZ_HALF && !lane[0]) || (size == SZ_WORD && lane == 2'b00);
  endfunction
endpackage

// File: rtl/dmem_load_ext.sv
// dmem_load_ext: picks the addressed byte/half out of a word and sign- or zero-extends it
module dmem_load_ext
  import pipe_dmem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  input  logic        unsgn,
  output logic [31:0] res
);
  logic [15:0] h;
  logic [7:0]  b;
  assign h = lane[1] ? word[31:16] : word[15:0];
  assign b = lane[0] ? h[15:8] : h[7:0];
  assign res = size == SZ_BYTE ? {{24{~unsgn & b[7]}}, b} :
               size == SZ_HALF ? {{16{~unsgn & h[15]}}, h} : word;
endmodule

// File: rtl/pipe_dmem_bhw.sv
// pipe_dmem_bhw: MEM-stage data RAM with byte/half/word access, misalignment flagging and a post-reset clear sweep
module pipe_dmem_bhw
  import pipe_dmem_pkg::*;
#(
  parameter int ADDR_W       = 5,
  parameter bit CLEAR_ON_RST = 1'b1
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        unsgn,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ready,
  output logic [31:0] rdata,
  output logic        rvalid,
  output logic        misalign
);
  localparam int DEPTH = 2 ** ADDR_W;
  logic [31:0] mem [DEPTH];
  state_t state, state_n;
  logic [ADDR_W-1:0] cnt, cnt_n, idx;
  logic acc, bad, unused_hi;
  logic [3:0] mask;
  logic [31:0] wrep, ext;
  assign ready = state == RUN;
  assign acc = req & ready;
  assign bad = !is_aligned(size, addr[1:0]);
  assign idx = addr[ADDR_W+1:2];
  assign unused_hi = ^addr[31:ADDR_W+2];
  assign mask = (acc & we & ~bad) ? lane_mask(size, addr[1:0]) : 4'b0000;
  assign wrep = size == SZ_BYTE ? {4{wdata[7:0]}} : size == SZ_HALF ? {2{wdata[15:0]}} : wdata;
  dmem_load_ext u_ext (
    .word  (mem[idx]),
    .lane  (addr[1:0]),
    .size  (size),
    .unsgn (unsgn),
    .res   (ext)
  );
  // sweep counter advances only while clearing; last word hands over to RUN
  always_comb begin
    cnt_n = state == CLEAR ? cnt + 1'b1 : cnt;
    state_n = (state == CLEAR && &cnt) ? RUN : state;
  end
  // state and sweep counter register
  always_ff @(posedge clk or negedge clrn)
    if (!clrn) begin
      state <= CLEAR_ON_RST ? CLEAR : RUN;
      cnt <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
    end
  // array write: clear sweep, otherwise lane-masked stores
  always_ff @(posedge clk)
    if (state == CLEAR) mem[cnt] <= '0;
    else for (int i = 0; i < 4; i++) if (mask[i]) mem[idx][8*i +: 8] <= wrep[8*i +: 8];
  // registered load result and status pulses; rdata holds between loads
  always_ff @(posedge clk or negedge clrn)
    if (!clrn) begin
      rvalid <= 1'b0;
      misalign <= 1'b0;
      rdata <= '0;
    end else begin
      rvalid <= acc & ~we;
      misalign <= acc & bad;
      if (acc & ~we) rdata <= bad ? '0 : ext;
    end
endmodule

// File: tb/tb_pipe_dmem_bhw.sv
// tb_pipe_dmem_bhw: table vectors, directed reset corners and randomized traffic against a byte-array model
module tb_pipe_dmem_bhw;
  localparam int ADDR_W = 5;
  localparam int DEPTH = 2 ** ADDR_W;
  localparam int NB = 4 * DEPTH;
  logic clk = 1'b0, clrn = 1'b0, req = 1'b0, we = 1'b0, unsgn = 1'b0;
  logic [1:0] size = 2'd0;
  logic [31:0] addr = '0, wdata = '0;
  logic ready, rvalid, misalign;
  logic [31:0] rdata;
  int checks = 0, failures = 0;
  logic [7:0] mb [NB];
  logic [31:0] m_rd;
  typedef struct {
    logic we; logic [1:0] sz; logic u; logic [31:0] a; logic [31:0] wd;
    logic rv; logic mis; logic [31:0] rd;
  } vec_t;
  vec_t tbl [19];

  always #5 clk = ~clk;

  pipe_dmem_bhw #(.ADDR_W(ADDR_W), .CLEAR_ON_RST(1'b1)) dut (
    .clk(clk), .clrn(clrn), .req(req), .we(we), .size(size), .unsgn(unsgn),
    .addr(addr), .wdata(wdata), .ready(ready), .rdata(rdata), .rvalid(rvalid), .misalign(misalign)
  );

  function automatic vec_t v(input logic w, input logic [1:0] sz, input logic u, input logic [31:0] a,
                             input logic [31:0] wd, input logic rv, input logic mis, input logic [31:0] rd);
    vec_t t;
    t.we = w; t.sz = sz; t.u = u; t.a = a; t.wd = wd; t.rv = rv; t.mis = mis; t.rd = rd;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic w, input logic [1:0] sz, input logic u,
                       input logic [31:0] a, input logic [31:0] wd);
    @(negedge clk);
    req = r; we = w; size = sz; unsgn = u; addr = a; wdata = wd;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string nm);
    int n;
    n = 0;
    @(negedge clk);
    req = 1'b0;
    clrn = 1'b1;
    while (!ready && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(nm, 32'(n), 32'(DEPTH));
  endtask

  function automatic logic m_bad(input logic [1:0] sz, input logic [31:0] a);
    return sz == 2'd3 || (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0);
  endfunction

  function automatic int m_len(input logic [1:0] sz);
    return sz == 2'd0 ? 1 : sz == 2'd1 ? 2 : 4;
  endfunction

  function automatic logic [31:0] m_load(input logic [1:0] sz, input logic u, input logic [31:0] a);
    int b, n;
    longint val;
    b = int'(a % NB);
    n = m_len(sz);
    val = 0;
    for (int i = n - 1; i >= 0; i--) val = val * 256 + longint'(mb[b + i]);
    if (!u && n < 4 && val >= (longint'(1) << (8 * n - 1))) val -= longint'(1) << (8 * n);
    return 32'(val);
  endfunction

  task automatic m_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
    int b;
    b = int'(a % NB);
    for (int i = 0; i < m_len(sz); i++) mb[b + i] = 8'(wd >> (8 * i));
  endtask

  initial begin
    tbl[0]  = v(1'b1, 2'd2, 1'b0, 32'h08, 32'h11223344, 1'b0, 1'b0, 32'h00000000);
    tbl[1]  = v(1'b1, 2'd0, 1'b0, 32'h09, 32'h000000AA, 1'b0, 1'b0, 32'h00000000);
    tbl[2]  = v(1'b0, 2'd2, 1'b0, 32'h08, 32'h0,        1'b1, 1'b0, 32'h1122AA44);
    tbl[3]  = v(1'b0, 2'd0, 1'b1, 32'h09, 32'h0,        1'b1, 1'b0, 32'h000000AA);
    tbl[4]  = v(1'b0, 2'd0, 1'b0, 32'h09, 32'h0,        1'b1, 1'b0, 32'hFFFFFFAA);
    tbl[5]  = v(1'b1, 2'd1, 1'b0, 32'h0E, 32'h00008001, 1'b0, 1'b0, 32'hFFFFFFAA);
    tbl[6]  = v(1'b0, 2'd1, 1'b0, 32'h0E, 32'h0,        1'b1, 1'b0, 32'hFFFF8001);
    tbl[7]  = v(1'b0, 2'd1, 1'b1, 32'h0E, 32'h0,        1'b1, 1'b0, 32'h00008001);
    tbl[8]  = v(1'b0, 2'd2, 1'b0, 32'h0C, 32'h0,        1'b1, 1'b0, 32'h80010000);
    tbl[9]  = v(1'b0, 2'd2, 1'b0, 32'h06, 32'h0,        1'b1, 1'b1, 32'h00000000);
    tbl[10] = v(1'b1, 2'd1, 1'b0, 32'h03, 32'h00005555, 1'b0, 1'b1, 32'h00000000);
    tbl[11] = v(1'b0, 2'd2, 1'b0, 32'h00, 32'h0,        1'b1, 1'b0, 32'h00000000);
    tbl[12] = v(1'b0, 2'd3, 1'b0, 32'h20, 32'h0,        1'b1, 1'b1, 32'h00000000);
    tbl[13] = v(1'b1, 2'd3, 1'b0, 32'h20, 32'hFFFFFFFF, 1'b0, 1'b1, 32'h00000000);
    tbl[14] = v(1'b0, 2'd2, 1'b0, 32'h20, 32'h0,        1'b1, 1'b0, 32'h00000000);
    tbl[15] = v(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0, 1'b0, 32'h00000000);
    tbl[16] = v(1'b0, 2'd2, 1'b0, 32'h10, 32'h0,        1'b1, 1'b0, 32'hDEADBEEF);
    tbl[17] = v(1'b0, 2'd2, 1'b0, 32'h90, 32'h0,        1'b1, 1'b0, 32'hDEADBEEF);
    tbl[18] = v(1'b0, 2'd2, 1'b0, 32'h08, 32'h0,        1'b1, 1'b0, 32'h1122AA44);

    #12;
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_misalign", 32'(misalign), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    wait_ready("clear_len");

    for (int i = 0; i < NB; i++) mb[i] = 8'h00;
    m_rd = 32'd0;
    for (int k = 0; k < 400; k++) begin
      logic r, w, u, erv, emis;
      logic [1:0] sz;
      logic [31:0] a, wd;
      r = $urandom_range(0, 4) != 0;
      w = 1'($urandom_range(0, 1));
      u = 1'($urandom_range(0, 1));
      sz = $urandom_range(0, 9) == 0 ? 2'd3 : 2'($urandom_range(0, 2));
      a = 32'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0) a = a - (a % 32'(m_len(sz)));
      wd = $urandom;
      erv = r && !w;
      emis = r && m_bad(sz, a);
      if (erv) m_rd = emis ? 32'd0 : m_load(sz, u, a);
      if (r && w && !emis) m_store(sz, a, wd);
      drive(r, w, sz, u, a, wd);
      chk("rnd_ready", 32'(ready), 32'd1);
      chk("rnd_rvalid", 32'(rvalid), 32'(erv));
      chk("rnd_misalign", 32'(misalign), 32'(emis));
      chk("rnd_rdata", rdata, m_rd);
    end

    @(negedge clk);
    req = 1'b0;
    clrn = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    clrn = 1'b1;
    repeat (10) @(posedge clk);
    #2;
    clrn = 1'b0;
    #1;
    chk("midclr_ready", 32'(ready), 32'd0);
    chk("midclr_rvalid", 32'(rvalid), 32'd0);
    wait_ready("clear_restart_len");

    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 1'b0, 2'd2, 1'b0, 32'(4 * i), 32'd0);
      chk($sformatf("clr_word%0d_rvalid", i), 32'(rvalid), 32'd1);
      chk($sformatf("clr_word%0d_rdata", i), rdata, 32'd0);
    end

    for (int i = 0; i < 19; i++) begin
      drive(1'b1, tbl[i].we, tbl[i].sz, tbl[i].u, tbl[i].a, tbl[i].wd);
      chk($sformatf("tbl%0d_rvalid", i), 32'(rvalid), 32'(tbl[i].rv));
      chk($sformatf("tbl%0d_misalign", i), 32'(misalign), 32'(tbl[i].mis));
      chk($sformatf("tbl%0d_rdata", i), rdata, tbl[i].rd);
    end

    @(negedge clk);
    req = 1'b1; we = 1'b0; size = 2'd2; unsgn = 1'b0; addr = 32'h08;
    clrn = 1'b0;
    @(posedge clk);
    #1;
    chk("pend_rvalid", 32'(rvalid), 32'd0);
    chk("pend_rdata", rdata, 32'd0);
    chk("pend_ready", 32'(ready), 32'd0);
    @(negedge clk);
    req = 1'b0;
    clrn = 1'b1;
    @(posedge clk);
    #1;
    chk("pend_after_rvalid", 32'(rvalid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
